player_cannon_ctrl: RTL and testbench

Player cannon controller, directly downstream of the three `edge_detector_debouncer` instances (left, right, fire). It consumes their one-cycle `o_debounced` pulses and maintains the cannon X position with saturation. It issues a single-outstanding fire request to the bullet engine over a req/ack handshake and tracks hit, explosion and lives.

---
 rtl/player_cannon_ctrl.sv | 200 ++++++++++++++++++++
 tb/tb_player_cannon_ctrl.sv | 202 ++++++++++++++++++++
 2 files changed

// File: rtl/player_cannon_ctrl.sv
// Player cannon controller: saturating X movement, single-outstanding fire
// request to the bullet engine, and hit/explosion/lives tracking.
module player_cannon_ctrl #(
    parameter int POS_W         = 9,
    parameter int X_MIN         = 8,
    parameter int X_MAX         = 200,
    parameter int X_RESET       = 104,
    parameter int STEP          = 2,
    parameter int EXPLODE_TICKS = 90,
    parameter int LIVES         = 3
) (
    input  logic             i_clk_36MHz,
    input  logic             i_reset,
    input  logic             i_enable,
    input  logic             i_left_pulse,
    input  logic             i_right_pulse,
    input  logic             i_fire_pulse,
    input  logic             i_fire_ack,
    input  logic             i_bullet_done,
    input  logic             i_player_hit,
    output logic [POS_W-1:0] o_x,
    output logic             o_fire_req,
    output logic [POS_W-1:0] o_fire_x,
    output logic             o_bullet_active,
    output logic             o_exploding,
    output logic [2:0]       o_lives,
    output logic             o_game_over
);

    localparam int                CNT_W        = $clog2(EXPLODE_TICKS + 1);
    localparam logic [CNT_W-1:0]  EXPLODE_LAST = CNT_W'(EXPLODE_TICKS - 1);
    localparam logic [POS_W:0]    X_MIN_W      = (POS_W + 1)'(X_MIN);
    localparam logic [POS_W:0]    X_MAX_W      = (POS_W + 1)'(X_MAX);
    localparam logic [POS_W:0]    STEP_W       = (POS_W + 1)'(STEP);
    localparam logic [POS_W-1:0]  X_RESET_V    = POS_W'(X_RESET);
    localparam logic [2:0]        LIVES_V      = 3'(LIVES);

    typedef enum logic [1:0] {
        C_ALIVE     = 2'd0,
        C_EXPLODING = 2'd1,
        C_GAME_OVER = 2'd2
    } cannon_state_t;

    typedef enum logic [1:0] {
        F_READY     = 2'd0,
        F_REQ       = 2'd1,
        F_IN_FLIGHT = 2'd2
    } fire_state_t;

    cannon_state_t    cannon_state_r, cannon_next_s;
    fire_state_t      fire_state_r, fire_next_s;
    logic [CNT_W-1:0] cnt_r, cnt_next_s;
    logic [POS_W-1:0] x_r, x_next_s;
    logic [POS_W-1:0] fire_x_r, fire_x_next_s;
    logic [2:0]       lives_r, lives_next_s;
    logic             fire_req_r, bullet_active_r, exploding_r, game_over_r;
    logic             hit_taken_s;
    logic [POS_W:0]   x_wide_s, x_left_s, x_right_s;

    // Saturating move targets, widened by one bit so neither end can wrap.
    always_comb begin
        x_wide_s = {1'b0, x_r};
        if (x_wide_s < (X_MIN_W + STEP_W)) begin
            x_left_s = X_MIN_W;
        end else begin
            x_left_s = x_wide_s - STEP_W;
        end
        if ((x_wide_s + STEP_W) > X_MAX_W) begin
            x_right_s = X_MAX_W;
        end else begin
            x_right_s = x_wide_s + STEP_W;
        end
    end

    // Cannon FSM next state: movement, hit handling, explosion timer, respawn.
    always_comb begin
        cannon_next_s = cannon_state_r;
        cnt_next_s    = cnt_r;
        x_next_s      = x_r;
        lives_next_s  = lives_r;
        hit_taken_s   = 1'b0;
        if (i_enable) begin
            case (cannon_state_r)
                C_ALIVE: begin
                    if (i_player_hit) begin
                        hit_taken_s = 1'b1;
                        if (lives_r > 3'd1) begin
                            cannon_next_s = C_EXPLODING;
                            lives_next_s  = lives_r - 3'd1;
                            cnt_next_s    = {CNT_W{1'b0}};
                        end else begin
                            cannon_next_s = C_GAME_OVER;
                            lives_next_s  = 3'd0;
                        end
                    end else if (i_left_pulse && !i_right_pulse) begin
                        x_next_s = x_left_s[POS_W-1:0];
                    end else if (i_right_pulse && !i_left_pulse) begin
                        x_next_s = x_right_s[POS_W-1:0];
                    end else begin
                        x_next_s = x_r;
                    end
                end
                C_EXPLODING: begin
                    if (cnt_r == EXPLODE_LAST) begin
                        cannon_next_s = C_ALIVE;
                        x_next_s      = X_RESET_V;
                        cnt_next_s    = {CNT_W{1'b0}};
                    end else begin
                        cnt_next_s = cnt_r + {{(CNT_W-1){1'b0}}, 1'b1};
                    end
                end
                C_GAME_OVER: begin
                    cannon_next_s = C_GAME_OVER;
                end
                default: begin
                    cannon_next_s = C_ALIVE;
                end
            endcase
        end else begin
            cannon_next_s = cannon_state_r;
        end
    end

    // Fire FSM next state; a hit in the same cycle as a fire pulse suppresses
    // the request, and an ack beats a simultaneous hit.
    always_comb begin
        fire_next_s   = fire_state_r;
        fire_x_next_s = fire_x_r;
        if (i_enable) begin
            case (fire_state_r)
                F_READY: begin
                    if (i_fire_pulse && (cannon_state_r == C_ALIVE) && !hit_taken_s) begin
                        fire_next_s   = F_REQ;
                        fire_x_next_s = x_r;
                    end else begin
                        fire_next_s = F_READY;
                    end
                end
                F_REQ: begin
                    if (i_fire_ack) begin
                        fire_next_s = F_IN_FLIGHT;
                    end else if (hit_taken_s) begin
                        fire_next_s = F_READY;
                    end else begin
                        fire_next_s = F_REQ;
                    end
                end
                F_IN_FLIGHT: begin
                    if (i_bullet_done) begin
                        fire_next_s = F_READY;
                    end else begin
                        fire_next_s = F_IN_FLIGHT;
                    end
                end
                default: begin
                    fire_next_s = F_READY;
                end
            endcase
        end else begin
            fire_next_s = fire_state_r;
        end
    end

    // State and output registers; outputs are decoded from next state so they
    // change on the same edge as the state they describe.
    always_ff @(posedge i_clk_36MHz) begin
        if (!i_reset) begin
            cannon_state_r  <= C_ALIVE;
            fire_state_r    <= F_READY;
            cnt_r           <= {CNT_W{1'b0}};
            x_r             <= X_RESET_V;
            fire_x_r        <= {POS_W{1'b0}};
            lives_r         <= LIVES_V;
            fire_req_r      <= 1'b0;
            bullet_active_r <= 1'b0;
            exploding_r     <= 1'b0;
            game_over_r     <= 1'b0;
        end else begin
            cannon_state_r  <= cannon_next_s;
            fire_state_r    <= fire_next_s;
            cnt_r           <= cnt_next_s;
            x_r             <= x_next_s;
            fire_x_r        <= fire_x_next_s;
            lives_r         <= lives_next_s;
            fire_req_r      <= (fire_next_s == F_REQ);
            bullet_active_r <= (fire_next_s == F_IN_FLIGHT);
            exploding_r     <= (cannon_next_s == C_EXPLODING);
            game_over_r     <= (cannon_next_s == C_GAME_OVER);
        end
    end

    assign o_x             = x_r;
    assign o_fire_req      = fire_req_r;
    assign o_fire_x        = fire_x_r;
    assign o_bullet_active = bullet_active_r;
    assign o_exploding     = exploding_r;
    assign o_lives         = lives_r;
    assign o_game_over     = game_over_r;

endmodule

// File: tb/tb_player_cannon_ctrl.sv
// Scoreboard bench for player_cannon_ctrl: stimulus pushes hand-derived
// expected outputs, a monitor pops and compares one entry per clock.
module tb_player_cannon_ctrl;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       en = 1'b0;
    logic       left = 1'b0, right = 1'b0, fire = 1'b0;
    logic       ack = 1'b0, done = 1'b0, hit = 1'b0;
    logic [8:0] o_x, o_fire_x;
    logic       o_fire_req, o_bullet_active, o_exploding, o_game_over;
    logic [2:0] o_lives;

    always #5 clk = ~clk;

    player_cannon_ctrl dut (
        .i_clk_36MHz    (clk),
        .i_reset        (rst_n),
        .i_enable       (en),
        .i_left_pulse   (left),
        .i_right_pulse  (right),
        .i_fire_pulse   (fire),
        .i_fire_ack     (ack),
        .i_bullet_done  (done),
        .i_player_hit   (hit),
        .o_x            (o_x),
        .o_fire_req     (o_fire_req),
        .o_fire_x       (o_fire_x),
        .o_bullet_active(o_bullet_active),
        .o_exploding    (o_exploding),
        .o_lives        (o_lives),
        .o_game_over    (o_game_over)
    );

    typedef struct packed {
        logic [63:0] tag;
        logic [8:0]  x;
        logic        req;
        logic [8:0]  fx;
        logic        act;
        logic        expl;
        logic [2:0]  lives;
        logic        go;
    } exp_t;

    exp_t       sbq[$];
    int         vectors = 0;
    int         miscompares = 0;

    logic [8:0] ex, efx;
    logic       ereq, eact, eexp, ego;
    logic [2:0] el;

    task automatic reset_exp();
        ex = 9'd104; efx = 9'd0; ereq = 1'b0; eact = 1'b0;
        eexp = 1'b0; el = 3'd3; ego = 1'b0;
    endtask

    // One clock of stimulus; the expected post-edge outputs are the current ex* values.
    task automatic cyc(input logic [63:0] tag, input logic r_n, input logic e,
                       input logic lp, input logic rp, input logic fp,
                       input logic ak, input logic dn, input logic ht);
        exp_t ent;
        @(posedge clk);
        #2;
        rst_n = r_n; en = e; left = lp; right = rp; fire = fp;
        ack = ak; done = dn; hit = ht;
        ent.tag = tag; ent.x = ex; ent.req = ereq; ent.fx = efx; ent.act = eact;
        ent.expl = eexp; ent.lives = el; ent.go = ego;
        sbq.push_back(ent);
    endtask

    // Monitor: compares the entry pushed before the edge that just occurred.
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (sbq.size() > 0) begin
                e = sbq.pop_front();
                vectors++;
                if ({o_x, o_fire_req, o_fire_x, o_bullet_active, o_exploding, o_lives, o_game_over} !==
                    {e.x, e.req, e.fx, e.act, e.expl, e.lives, e.go}) begin
                    miscompares++;
                    $display("FAIL %s: got x=%0d req=%0b fx=%0d act=%0b expl=%0b lives=%0d go=%0b, want x=%0d req=%0b fx=%0d act=%0b expl=%0b lives=%0d go=%0b",
                             e.tag, o_x, o_fire_req, o_fire_x, o_bullet_active, o_exploding, o_lives, o_game_over,
                             e.x, e.req, e.fx, e.act, e.expl, e.lives, e.go);
                end
            end
        end
    end

    initial begin
        reset_exp();
        cyc("reset", 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        cyc("reset2", 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1);

        // Walk left to the lower limit and hold there.
        for (int i = 0; i < 60; i++) begin
            ex = (ex >= 9'd10) ? ex - 9'd2 : 9'd8;
            cyc("left", 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        end
        // Walk right to the upper limit and hold there.
        for (int i = 0; i < 100; i++) begin
            ex = (ex + 9'd2 > 9'd200) ? 9'd200 : ex + 9'd2;
            cyc("right", 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        end

        reset_exp();
        cyc("rst_mid", 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        cyc("both_lr", 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        cyc("en0_l", 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        cyc("en0_f", 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
        cyc("en0_hit", 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);

        // Move to X=50 and fire with the ack held off.
        for (int i = 0; i < 27; i++) begin
            ex = ex - 9'd2;
            cyc("to50", 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        end
        ereq = 1'b1; efx = 9'd50;
        cyc("fire50", 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
        cyc("req_w1", 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        ex = 9'd48;
        cyc("req_mv", 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        cyc("req_dn", 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
        cyc("req_fp", 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
        cyc("req_w5", 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        ereq = 1'b0; eact = 1'b1;
        cyc("ack", 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
        cyc("fly_fp", 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
        eact = 1'b0;
        cyc("done", 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);

        // Fire together with a move latches the pre-move X.
        ex = 9'd46; ereq = 1'b1; efx = 9'd48;
        cyc("fire_mv", 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
        // Hit while requesting withdraws the request and starts the explosion.
        ereq = 1'b0; eexp = 1'b1; el = 3'd2;
        cyc("hit_req", 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
        for (int i = 1; i <= 89; i++) begin
            cyc("expl", 1'b1, 1'b1, logic'(i % 2), 1'b0, logic'(i == 30), 1'b0, 1'b0, logic'(i == 40));
        end
        eexp = 1'b0; ex = 9'd104;
        cyc("respawn", 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);

        // Ack and hit together: the bullet still launches and finishes normally.
        ereq = 1'b1; efx = 9'd104;
        cyc("fire2", 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
        ereq = 1'b0; eact = 1'b1; eexp = 1'b1; el = 3'd1;
        cyc("ack_hit", 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1);
        eact = 1'b0;
        cyc("done_ex", 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
        for (int i = 0; i < 88; i++) begin
            cyc("expl2", 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        end
        eexp = 1'b0;
        cyc("respawn2", 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);

        // Last life lost with a bullet in flight.
        ereq = 1'b1;
        cyc("fire3", 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
        ereq = 1'b0; eact = 1'b1;
        cyc("ack3", 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
        el = 3'd0; ego = 1'b1;
        cyc("gameover", 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
        cyc("go_inp", 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1);
        eact = 1'b0;
        cyc("go_done", 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
        cyc("go_fire", 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
        cyc("go_right", 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);

        // Reset while exploding with a bullet in flight.
        reset_exp();
        cyc("rst_go", 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        ereq = 1'b1; efx = 9'd104;
        cyc("fire4", 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
        ereq = 1'b0; eact = 1'b1;
        cyc("ack4", 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
        eexp = 1'b1; el = 3'd2;
        cyc("hit4", 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
        for (int i = 0; i < 3; i++) begin
            cyc("expl4", 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        end
        reset_exp();
        cyc("rst_exp", 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1);
        cyc("post_rst", 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        ex = 9'd102;
        cyc("alive_mv", 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        cyc("idle", 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);

        repeat (3) @(posedge clk);
        #3;
        if (sbq.size() != 0) begin
            miscompares++;
            $display("FAIL drain: %0d entries left unchecked, want 0", sbq.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
